bpsk_frame_scheduler: RTL and testbench

- Ping-pong frame buffer controller and transmit sequencer in front of the BPSK phase controller.
- A host/PS byte stream fills one half of a dual-port BRAM while the modulator reads the other half. The scheduler triggers each transmission, waits for completion, enforces an inter-frame gap, and swaps banks.
- It sits between the PS-side data source, the frame BRAM, and the phase-control modulator.

---
 rtl/bpsk_frame_scheduler.sv | 125 ++++++++++++
 tb/tb_bpsk_frame_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_frame_scheduler.sv
// Ping-pong frame buffer controller: fills one BRAM bank from the host stream
// while the modulator reads the other, and sequences trigger / done / gap / swap.
module bpsk_frame_scheduler #(
   parameter int unsigned data_width     = 8,
   parameter int unsigned addr_width     = 8,
   parameter int unsigned frame_length   = 150,
   parameter int unsigned gap_cycles     = 1000,
   parameter int unsigned timeout_cycles = 2000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   input  logic [data_width-1:0] wr_data,
   input  logic                  wr_last,
   output logic                  wr_ready,
   output logic                  send_signal,
   input  logic                  tx_done,
   input  logic                  mod_ram_en,
   input  logic [addr_width-1:0] mod_ram_addr,
   output logic [data_width-1:0] mod_ram_rd_data,
   output logic                  bram_a_en,
   output logic                  bram_a_we,
   output logic [addr_width:0]   bram_a_addr,
   output logic [data_width-1:0] bram_a_wr_data,
   output logic                  bram_b_en,
   output logic [addr_width:0]   bram_b_addr,
   input  logic [data_width-1:0] bram_b_rd_data,
   output logic [1:0]            bank_full,
   output logic [15:0]           frames_sent,
   output logic                  len_err,
   output logic                  timeout_err
);

   localparam logic [addr_width-1:0] last_ptr     = addr_width'(frame_length - 1);
   localparam logic [31:0]           timeout_last = 32'(timeout_cycles - 1);
   localparam logic [31:0]           gap_last     = 32'(gap_cycles - 1);

   typedef enum logic [1:0] {IDLE, START, BUSY, GAP} tx_state_t;

   tx_state_t             state, state_next;
   logic                  wr_bank, rd_bank;
   logic [addr_width-1:0] wr_ptr;
   logic [31:0]           cnt;
   logic                  accept, close, bank_release, timed_out;
   logic [1:0]            set_mask, clr_mask;

   assign wr_ready     = !bank_full[wr_bank];
   assign accept       = wr_valid && wr_ready;
   assign close        = accept && (wr_last || (wr_ptr == last_ptr));
   assign bank_release = (state == BUSY) && (tx_done || (cnt == timeout_last));
   assign timed_out    = (state == BUSY) && !tx_done && (cnt == timeout_last);

   // Independent set/clear per bank so a close and a release on opposite banks both land.
   assign set_mask = {close && wr_bank, close && !wr_bank};
   assign clr_mask = {bank_release && rd_bank, bank_release && !rd_bank};

   assign bram_b_en       = mod_ram_en;
   assign bram_b_addr     = {rd_bank, mod_ram_addr};
   assign mod_ram_rd_data = bram_b_rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank        <= 1'b0;
         wr_ptr         <= '0;
         bram_a_en      <= 1'b0;
         bram_a_we      <= 1'b0;
         bram_a_addr    <= '0;
         bram_a_wr_data <= '0;
         len_err        <= 1'b0;
      end else begin
         bram_a_en <= accept;
         bram_a_we <= accept;
         len_err   <= close && !wr_last;
         if (accept) begin
            bram_a_addr    <= {wr_bank, wr_ptr};
            bram_a_wr_data <= wr_data;
            if (close) begin
               wr_ptr  <= '0;
               wr_bank <= !wr_bank;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rd_bank     <= 1'b0;
         bank_full   <= '0;
         frames_sent <= '0;
         timeout_err <= 1'b0;
         cnt         <= '0;
      end else begin
         state       <= state_next;
         bank_full   <= (bank_full | set_mask) & ~clr_mask;
         timeout_err <= timed_out;
         if (bank_release) rd_bank <= !rd_bank;
         if ((state == BUSY) && tx_done) frames_sent <= frames_sent + 16'd1;
         // One counter serves both BUSY timeout and GAP length; it restarts at each phase entry.
         case (state)
            BUSY:    cnt <= bank_release ? '0 : cnt + 32'd1;
            GAP:     cnt <= cnt + 32'd1;
            default: cnt <= '0;
         endcase
      end
   end

   always_comb begin
      state_next  = state;
      send_signal = 1'b0;
      case (state)
         IDLE:  if (bank_full[rd_bank]) state_next = START;
         START: begin
            send_signal = 1'b1;
            state_next  = BUSY;
         end
         BUSY:  if (bank_release) state_next = GAP;
         GAP:   if (cnt == gap_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bpsk_frame_scheduler.sv
// Directed bench for bpsk_frame_scheduler: frame fill, bank stall, length/timeout
// errors, read-bank mapping, gap timing and reset during transmission.
module tb_bpsk_frame_scheduler;

   localparam int unsigned FL  = 150;
   localparam int unsigned GAP = 20;
   localparam int unsigned TO  = 400;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = '0;
   logic       wr_last = 1'b0;
   logic       wr_ready;
   logic       send_signal;
   logic       tx_done = 1'b0;
   logic       mod_ram_en = 1'b0;
   logic [7:0] mod_ram_addr = '0;
   logic [7:0] mod_ram_rd_data;
   logic       bram_a_en, bram_a_we;
   logic [8:0] bram_a_addr;
   logic [7:0] bram_a_wr_data;
   logic       bram_b_en;
   logic [8:0] bram_b_addr;
   logic [7:0] bram_b_rd_data = '0;
   logic [1:0] bank_full;
   logic [15:0] frames_sent;
   logic       len_err, timeout_err;

   int errors = 0;
   int checks = 0;

   bpsk_frame_scheduler #(
      .data_width(8), .addr_width(8), .frame_length(FL),
      .gap_cycles(GAP), .timeout_cycles(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
      .send_signal(send_signal), .tx_done(tx_done),
      .mod_ram_en(mod_ram_en), .mod_ram_addr(mod_ram_addr), .mod_ram_rd_data(mod_ram_rd_data),
      .bram_a_en(bram_a_en), .bram_a_we(bram_a_we), .bram_a_addr(bram_a_addr),
      .bram_a_wr_data(bram_a_wr_data),
      .bram_b_en(bram_b_en), .bram_b_addr(bram_b_addr), .bram_b_rd_data(bram_b_rd_data),
      .bank_full(bank_full), .frames_sent(frames_sent),
      .len_err(len_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; tx_done = 1'b0;
      mod_ram_en = 1'b0; mod_ram_addr = '0;
      tick; tick;
      rst = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] d, input logic last);
      int w;
      w = 0;
      wr_valid = 1'b1; wr_data = d; wr_last = last;
      while (!wr_ready && w < 1000) begin tick; w++; end
      if (!wr_ready) begin
         checks++; errors++;
         $display("FAIL write_stall: wr_ready=%b after %0d cycles, required 1", wr_ready, w);
      end
      tick;
      wr_valid = 1'b0; wr_last = 1'b0;
   endtask

   task automatic write_frame(input int n, input logic [7:0] base, input logic last);
      for (int i = 0; i < n; i++) write_byte(base + 8'(i), last && (i == n - 1));
   endtask

   task automatic wait_send(output int n);
      n = 0;
      while (!send_signal && n < 200) begin tick; n++; end
   endtask

   task automatic test_reset;
      rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h55;
      tick; tick;
      checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL rst_bank_full: got %b required 00", bank_full); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %b required 1", wr_ready); end
      checks++; if (send_signal !== 1'b0) begin errors++; $display("FAIL rst_send: got %b required 0", send_signal); end
      checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL rst_frames: got %0d required 0", frames_sent); end
      checks++; if (bram_a_en !== 1'b0) begin errors++; $display("FAIL rst_a_en: got %b required 0", bram_a_en); end
      checks++; if ({len_err, timeout_err} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b required 00", {len_err, timeout_err}); end
      rst = 1'b0; wr_valid = 1'b0;
   endtask

   task automatic test_single_frame;
      int bad_a, bad_rdy, bad_send;
      do_reset;
      bad_a = 0; bad_rdy = 0; bad_send = 0;
      for (int i = 0; i < 150; i++) begin
         wr_valid = 1'b1; wr_data = 8'(i); wr_last = (i == 149);
         if (wr_ready !== 1'b1) bad_rdy++;
         tick;
         if (!(bram_a_en === 1'b1 && bram_a_we === 1'b1 && bram_a_addr === 9'(i) && bram_a_wr_data === 8'(i))) bad_a++;
         if (send_signal !== 1'b0) bad_send++;
      end
      wr_valid = 1'b0; wr_last = 1'b0;
      checks++; if (bad_a != 0) begin errors++; $display("FAIL fill_port_a: %0d bad writes, required 0", bad_a); end
      checks++; if (bad_rdy != 0) begin errors++; $display("FAIL fill_ready: %0d not-ready cycles, required 0", bad_rdy); end
      checks++; if (bad_send != 0) begin errors++; $display("FAIL fill_early_send: %0d early sends, required 0", bad_send); end
      checks++; if (bank_full !== 2'b01) begin errors++; $display("FAIL fill_bank_full: got %b required 01", bank_full); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL fill_wr_ready: got %b required 1", wr_ready); end
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL fill_len_err: got %b required 0", len_err); end
      tick;
      checks++; if (send_signal !== 1'b1) begin errors++; $display("FAIL fill_send_pulse: got %b required 1", send_signal); end
      tick;
      checks++; if (send_signal !== 1'b0) begin errors++; $display("FAIL fill_send_single: got %b required 0", send_signal); end
      tx_done = 1'b1; tick; tx_done = 1'b0;
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL fill_frames: got %0d required 1", frames_sent); end
      checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL fill_release: got %b required 00", bank_full); end
   endtask

   task automatic test_back_to_back;
      int bad;
      do_reset;
      write_frame(150, 8'h00, 1'b1);
      write_frame(150, 8'h00, 1'b1);
      checks++; if (bank_full !== 2'b11) begin errors++; $display("FAIL b2b_full: got %b required 11", bank_full); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b required 0", wr_ready); end
      wr_valid = 1'b1; wr_data = 8'hA5; wr_last = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin tick; if (bram_a_en !== 1'b0) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_stall: %0d writes while full, required 0", bad); end
      tx_done = 1'b1; tick; tx_done = 1'b0;
      checks++; if (bank_full !== 2'b10) begin errors++; $display("FAIL b2b_release: got %b required 10", bank_full); end
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL b2b_frames: got %0d required 1", frames_sent); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_again: got %b required 1", wr_ready); end
      tick;
      wr_valid = 1'b0;
      checks++; if (!(bram_a_en === 1'b1 && bram_a_we === 1'b1 && bram_a_addr === 9'h000 && bram_a_wr_data === 8'hA5)) begin
         errors++;
         $display("FAIL b2b_stalled_write: en=%b we=%b addr=%h data=%h required 1 1 000 a5", bram_a_en, bram_a_we, bram_a_addr, bram_a_wr_data);
      end
   endtask

   task automatic test_len_err;
      int bad;
      do_reset;
      write_frame(10, 8'h10, 1'b1);
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_short_err: got %b required 0", len_err); end
      checks++; if (bank_full !== 2'b01) begin errors++; $display("FAIL len_short_full: got %b required 01", bank_full); end
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         write_byte(8'(i), 1'b0);
         if (i < 149 && len_err !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL len_early: %0d early pulses, required 0", bad); end
      checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_pulse: got %b required 1", len_err); end
      checks++; if (bank_full !== 2'b11) begin errors++; $display("FAIL len_full: got %b required 11", bank_full); end
      checks++; if (bram_a_addr !== 9'h195) begin errors++; $display("FAIL len_last_addr: got %h required 195", bram_a_addr); end
      tick;
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_single: got %b required 0", len_err); end
   endtask

   task automatic test_timeout;
      int n, k;
      do_reset;
      write_frame(10, 8'h00, 1'b1);
      wait_send(n);
      checks++; if (n >= 200) begin errors++; $display("FAIL to_send_wait: no send in %0d cycles", n); end
      write_frame(10, 8'h20, 1'b1);
      k = 10;
      while (timeout_err !== 1'b1 && k < 450) begin tick; k++; end
      checks++; if (k != TO + 1) begin errors++; $display("FAIL to_when: pulse seen %0d cycles after START, required %0d", k, TO + 1); end
      checks++; if (bank_full !== 2'b10) begin errors++; $display("FAIL to_release: got %b required 10", bank_full); end
      checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL to_frames: got %0d required 0", frames_sent); end
      tick; n = 1;
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_single: got %b required 0", timeout_err); end
      while (!send_signal && n < 200) begin tick; n++; end
      checks++; if (n != GAP + 1) begin errors++; $display("FAIL to_gap: send after %0d cycles, required %0d", n, GAP + 1); end
      checks++; if (bram_b_addr !== 9'h100) begin errors++; $display("FAIL to_next_bank: got %h required 100", bram_b_addr); end
   endtask

   task automatic test_bank_map;
      int n;
      do_reset;
      write_frame(10, 8'h00, 1'b1);
      wait_send(n);
      checks++; if (n >= 200) begin errors++; $display("FAIL map_send_wait: no send in %0d cycles", n); end
      tick;
      write_frame(10, 8'h40, 1'b1);
      mod_ram_en = 1'b1; mod_ram_addr = 8'h05; bram_b_rd_data = 8'h3C;
      #1;
      checks++; if (bram_b_en !== 1'b1) begin errors++; $display("FAIL map_b_en: got %b required 1", bram_b_en); end
      checks++; if (bram_b_addr !== 9'h005) begin errors++; $display("FAIL map_bank0: got %h required 005", bram_b_addr); end
      checks++; if (mod_ram_rd_data !== 8'h3C) begin errors++; $display("FAIL map_rd_data: got %h required 3c", mod_ram_rd_data); end
      tx_done = 1'b1; tick; tx_done = 1'b0; n = 1;
      checks++; if (bram_b_addr !== 9'h105) begin errors++; $display("FAIL map_bank1: got %h required 105", bram_b_addr); end
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL map_frames: got %0d required 1", frames_sent); end
      tx_done = 1'b1; tick; tx_done = 1'b0; n = 2;
      checks++; if (frames_sent !== 16'd1 || bank_full !== 2'b10) begin
         errors++; $display("FAIL map_done_in_gap: frames=%0d full=%b required 1 10", frames_sent, bank_full);
      end
      while (!send_signal && n < 200) begin tick; n++; end
      checks++; if (n != GAP + 2) begin errors++; $display("FAIL map_gap: done-to-send %0d cycles, required %0d", n, GAP + 2); end
      mod_ram_en = 1'b0;
   endtask

   task automatic test_reset_busy;
      int n, bad;
      do_reset;
      write_frame(10, 8'h00, 1'b1);
      write_frame(10, 8'h10, 1'b1);
      tx_done = 1'b1; tick; tx_done = 1'b0;
      write_frame(10, 8'h20, 1'b1);
      wait_send(n);
      checks++; if (n >= 200) begin errors++; $display("FAIL rb_send_wait: no send in %0d cycles", n); end
      tick;
      checks++; if (bank_full !== 2'b11 || frames_sent !== 16'd1) begin
         errors++; $display("FAIL rb_pre: full=%b frames=%0d required 11 1", bank_full, frames_sent);
      end
      mod_ram_addr = 8'h05;
      rst = 1'b1; tick; rst = 1'b0;
      checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL rb_full: got %b required 00", bank_full); end
      checks++; if (send_signal !== 1'b0) begin errors++; $display("FAIL rb_send: got %b required 0", send_signal); end
      checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL rb_frames: got %0d required 0", frames_sent); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rb_ready: got %b required 1", wr_ready); end
      checks++; if (bram_b_addr !== 9'h005) begin errors++; $display("FAIL rb_rd_bank: got %h required 005", bram_b_addr); end
      bad = 0;
      for (int i = 0; i < 5; i++) begin tick; if (send_signal !== 1'b0) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL rb_idle: %0d sends after reset, required 0", bad); end
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_back_to_back;
      test_len_err;
      test_timeout;
      test_bank_map;
      test_reset_busy;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
